// File: rtl/sc_comp_dataflow.sv
// sc_comp_dataflow: single-cycle MIPS32-subset computer (CPU core, register file, instruction ROM, data RAM).
// Optional macro SCCOMP_HALT_EN: 'break' (32'h0000_000D) freezes the pc and all writes until reset.
`timescale 1ns/1ps

module sc_regfile (
  input  logic        clk_in,
  input  logic        rst_n,
  input  logic        we,
  input  logic [4:0]  waddr,
  input  logic [31:0] wdata,
  input  logic [4:0]  raddr_a,
  input  logic [4:0]  raddr_b,
  output logic [31:0] rdata_a,
  output logic [31:0] rdata_b
);
  logic [31:0] array_reg [0:31];

  // $0 is never written, so it keeps its reset value of zero
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 32; i++) begin
        array_reg[i] <= 32'd0;
      end
    end else if (we && (waddr != 5'd0)) begin
      array_reg[waddr] <= wdata;
    end
  end

  always_comb begin
    rdata_a = (raddr_a == 5'd0) ? 32'd0 : array_reg[raddr_a];
    rdata_b = (raddr_b == 5'd0) ? 32'd0 : array_reg[raddr_b];
  end
endmodule

module sc_cpu #(
  parameter logic [31:0] PC_RESET = 32'h0040_0000
) (
  input  logic        clk_in,
  input  logic        rst_n,
  input  logic [31:0] inst,
  input  logic [31:0] dmem_rdata,
  output logic [31:0] pc,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  output logic        dmem_we
);
  localparam logic [5:0] OP_SPECIAL = 6'h00;
  localparam logic [5:0] OP_J       = 6'h02;
  localparam logic [5:0] OP_JAL     = 6'h03;
  localparam logic [5:0] OP_BEQ     = 6'h04;
  localparam logic [5:0] OP_BNE     = 6'h05;
  localparam logic [5:0] OP_ADDIU   = 6'h09;
  localparam logic [5:0] OP_SLTI    = 6'h0A;
  localparam logic [5:0] OP_SLTIU   = 6'h0B;
  localparam logic [5:0] OP_ANDI    = 6'h0C;
  localparam logic [5:0] OP_ORI     = 6'h0D;
  localparam logic [5:0] OP_XORI    = 6'h0E;
  localparam logic [5:0] OP_LUI     = 6'h0F;
  localparam logic [5:0] OP_LW      = 6'h23;
  localparam logic [5:0] OP_SW      = 6'h2B;

  localparam logic [5:0] F_SLL  = 6'h00;
  localparam logic [5:0] F_SRL  = 6'h02;
  localparam logic [5:0] F_SRA  = 6'h03;
  localparam logic [5:0] F_JR   = 6'h08;
  localparam logic [5:0] F_ADDU = 6'h21;
  localparam logic [5:0] F_SUBU = 6'h23;
  localparam logic [5:0] F_AND  = 6'h24;
  localparam logic [5:0] F_OR   = 6'h25;
  localparam logic [5:0] F_XOR  = 6'h26;
  localparam logic [5:0] F_NOR  = 6'h27;
  localparam logic [5:0] F_SLT  = 6'h2A;
  localparam logic [5:0] F_SLTU = 6'h2B;

  logic [31:0] pc_q, pc_d;
  logic [5:0]  op_s, funct_s;
  logic [4:0]  rs_s, rt_s, rd_s, shamt_s;
  logic [31:0] rs_val_s, rt_val_s, sext_imm_s, zext_imm_s;
  logic [31:0] pc_plus4_s, br_target_s, jmp_target_s, next_pc_s;
  logic        wb_en_s, rf_we_s, is_sw_s, halt_s;
  logic [4:0]  wb_addr_s;
  logic [31:0] wb_data_s;

  assign op_s         = inst[31:26];
  assign rs_s         = inst[25:21];
  assign rt_s         = inst[20:16];
  assign rd_s         = inst[15:11];
  assign shamt_s      = inst[10:6];
  assign funct_s      = inst[5:0];
  assign sext_imm_s   = {{16{inst[15]}}, inst[15:0]};
  assign zext_imm_s   = {16'd0, inst[15:0]};
  assign pc_plus4_s   = pc_q + 32'd4;
  assign br_target_s  = pc_plus4_s + {sext_imm_s[29:0], 2'b00};
  assign jmp_target_s = {pc_plus4_s[31:28], inst[25:0], 2'b00};

`ifdef SCCOMP_HALT_EN
  localparam logic [31:0] BREAK_INST = 32'h0000_000D;
  assign halt_s = (inst == BREAK_INST);
`else
  assign halt_s = 1'b0;
`endif

  sc_regfile cpu_ref (
    .clk_in  (clk_in),
    .rst_n   (rst_n),
    .we      (rf_we_s),
    .waddr   (wb_addr_s),
    .wdata   (wb_data_s),
    .raddr_a (rs_s),
    .raddr_b (rt_s),
    .rdata_a (rs_val_s),
    .rdata_b (rt_val_s)
  );

  // Decode and execute; unsupported encodings fall through as a plain pc+4
  always_comb begin
    wb_en_s   = 1'b0;
    wb_addr_s = rt_s;
    wb_data_s = 32'd0;
    is_sw_s   = 1'b0;
    next_pc_s = pc_plus4_s;
    case (op_s)
      OP_SPECIAL: begin
        wb_addr_s = rd_s;
        wb_en_s   = 1'b1;
        case (funct_s)
          F_SLL:   wb_data_s = rt_val_s << shamt_s;
          F_SRL:   wb_data_s = rt_val_s >> shamt_s;
          F_SRA:   wb_data_s = $signed(rt_val_s) >>> shamt_s;
          F_JR: begin
            wb_en_s   = 1'b0;
            next_pc_s = rs_val_s;
          end
          F_ADDU:  wb_data_s = rs_val_s + rt_val_s;
          F_SUBU:  wb_data_s = rs_val_s - rt_val_s;
          F_AND:   wb_data_s = rs_val_s & rt_val_s;
          F_OR:    wb_data_s = rs_val_s | rt_val_s;
          F_XOR:   wb_data_s = rs_val_s ^ rt_val_s;
          F_NOR:   wb_data_s = ~(rs_val_s | rt_val_s);
          F_SLT:   wb_data_s = {31'd0, $signed(rs_val_s) < $signed(rt_val_s)};
          F_SLTU:  wb_data_s = {31'd0, rs_val_s < rt_val_s};
          default: wb_en_s = 1'b0;
        endcase
      end
      OP_J:     next_pc_s = jmp_target_s;
      OP_JAL: begin
        wb_en_s   = 1'b1;
        wb_addr_s = 5'd31;
        wb_data_s = pc_plus4_s;
        next_pc_s = jmp_target_s;
      end
      OP_BEQ:   next_pc_s = (rs_val_s == rt_val_s) ? br_target_s : pc_plus4_s;
      OP_BNE:   next_pc_s = (rs_val_s != rt_val_s) ? br_target_s : pc_plus4_s;
      OP_ADDIU: begin wb_en_s = 1'b1; wb_data_s = rs_val_s + sext_imm_s; end
      OP_SLTI:  begin wb_en_s = 1'b1; wb_data_s = {31'd0, $signed(rs_val_s) < $signed(sext_imm_s)}; end
      OP_SLTIU: begin wb_en_s = 1'b1; wb_data_s = {31'd0, rs_val_s < sext_imm_s}; end
      OP_ANDI:  begin wb_en_s = 1'b1; wb_data_s = rs_val_s & zext_imm_s; end
      OP_ORI:   begin wb_en_s = 1'b1; wb_data_s = rs_val_s | zext_imm_s; end
      OP_XORI:  begin wb_en_s = 1'b1; wb_data_s = rs_val_s ^ zext_imm_s; end
      OP_LUI:   begin wb_en_s = 1'b1; wb_data_s = {inst[15:0], 16'd0}; end
      OP_LW:    begin wb_en_s = 1'b1; wb_data_s = dmem_rdata; end
      OP_SW:    is_sw_s = 1'b1;
      default:  next_pc_s = pc_plus4_s;
    endcase
  end

  always_comb begin
    rf_we_s    = wb_en_s & ~halt_s;
    pc_d       = halt_s ? pc_q : next_pc_s;
    dmem_addr  = rs_val_s + sext_imm_s;
    dmem_wdata = rt_val_s;
    // RAM has no reset, so stores are explicitly suppressed while reset is held
    dmem_we    = is_sw_s & ~halt_s & rst_n;
  end

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      pc_q <= PC_RESET;
    end else begin
      pc_q <= pc_d;
    end
  end

  assign pc = pc_q;
endmodule

module sc_comp_dataflow #(
  parameter logic [31:0] PC_RESET   = 32'h0040_0000,
  parameter logic [31:0] DMEM_BASE  = 32'h1001_0000,
  parameter int          IMEM_DEPTH = 2048,
  parameter int          DMEM_DEPTH = 2048
) (
  input  logic        clk_in,
  input  logic        reset,
  output logic [31:0] inst,
  output logic [31:0] pc
);
  localparam int IMEM_AW = $clog2(IMEM_DEPTH);
  localparam int DMEM_AW = $clog2(DMEM_DEPTH);

  logic [31:0]        rom_mem [0:IMEM_DEPTH-1];
  logic [31:0]        ram_mem [0:DMEM_DEPTH-1];
  logic [31:0]        imem_off_s, dmem_off_s, dmem_addr_s, dmem_wdata_s, dmem_rdata_s;
  logic [IMEM_AW-1:0] imem_idx_s;
  logic [DMEM_AW-1:0] dmem_idx_s;
  logic               dmem_we_s;
  logic               unused_s;

  // Word addressing: byte-offset bits and anything beyond the array depth wrap away
  assign imem_off_s   = pc - PC_RESET;
  assign imem_idx_s   = imem_off_s[IMEM_AW+1:2];
  assign inst         = rom_mem[imem_idx_s];
  assign dmem_off_s   = dmem_addr_s - DMEM_BASE;
  assign dmem_idx_s   = dmem_off_s[DMEM_AW+1:2];
  assign dmem_rdata_s = ram_mem[dmem_idx_s];
  assign unused_s     = ^{imem_off_s[31:IMEM_AW+2], imem_off_s[1:0],
                          dmem_off_s[31:DMEM_AW+2], dmem_off_s[1:0]};

  sc_cpu #(.PC_RESET(PC_RESET)) sccpu (
    .clk_in     (clk_in),
    .rst_n      (reset),
    .inst       (inst),
    .dmem_rdata (dmem_rdata_s),
    .pc         (pc),
    .dmem_addr  (dmem_addr_s),
    .dmem_wdata (dmem_wdata_s),
    .dmem_we    (dmem_we_s)
  );

  always_ff @(posedge clk_in) begin
    if (dmem_we_s) begin
      ram_mem[dmem_idx_s] <= dmem_wdata_s;
    end
  end
endmodule

// File: tb/tb_sc_comp_dataflow.sv
// Bench for sc_comp_dataflow: an instruction-level model runs alongside the DUT and is compared every cycle,
// with literal expectations pinning both at key points of two directed programs.
`timescale 1ns/1ps

module tb_sc_comp_dataflow;
  localparam logic [31:0] PC_RESET  = 32'h0040_0000;
  localparam logic [31:0] DMEM_BASE = 32'h1001_0000;

  logic        clk_in = 1'b0;
  logic        reset  = 1'b0;
  logic [31:0] inst, pc;

  int n_checks = 0;
  int n_errors = 0;

  logic [31:0] m_prog [0:2047];
  logic [31:0] m_reg  [0:31];
  logic [31:0] m_mem  [int];
  logic [31:0] m_pc;

  sc_comp_dataflow dut (.clk_in(clk_in), .reset(reset), .inst(inst), .pc(pc));

  always #5 clk_in = ~clk_in;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h", name, got, want);
    end
  endtask

  function automatic int rom_index(input logic [31:0] a);
    return int'(((a - PC_RESET) >> 2) % 32'd2048);
  endfunction

  function automatic logic [31:0] gpr(input int i);
    return dut.sccpu.cpu_ref.array_reg[i];
  endfunction

  // Load the same image into the model and the DUT ROM (only while reset is held)
  task automatic load_prog(input int which);
    logic [31:0] img [0:17];
    if (which == 0) begin
      img = '{32'h340100FF, 32'h3C028000, 32'h00221821, 32'h00022103,
              32'h0C100010, 32'h0041282A, 32'h0041302B, 32'h3C071001,
              32'hACE30004, 32'h8CE80004, 32'h00220021, 32'h14210003,
              32'h01015023, 32'h1000FFFF, 32'h00000000, 32'h00000000,
              32'h34091234, 32'h03E00008};
    end else begin
      img = '{32'h3401F0F0, 32'h3822FFFF, 32'h00221827, 32'h00012200,
              32'h00032902, 32'h2C26FFFF, 32'h28670000, 32'h30688001,
              32'h0000000D, 32'h00224825, 32'h00245026, 32'h00225824,
              32'h240CFFFE, 32'h0810000D, 32'h00000000, 32'h00000000,
              32'h00000000, 32'h00000000};
    end
    for (int i = 0; i < 2048; i++) begin
      m_prog[i] = (i < 18) ? img[i] : 32'd0;
      dut.rom_mem[i] = m_prog[i];
    end
  endtask

  // Architectural model: one whole instruction per rising edge
  task automatic model_step();
    logic [31:0] w, a, b, simm, res, npc, ea;
    logic [4:0]  dst;
    logic        wr;
    int          k;
    w    = m_prog[rom_index(m_pc)];
    a    = m_reg[w[25:21]];
    b    = m_reg[w[20:16]];
    simm = {{16{w[15]}}, w[15:0]};
    ea   = a + simm;
    k    = int'(((ea - DMEM_BASE) >> 2) % 32'd2048);
    npc  = m_pc + 32'd4;
    dst  = w[20:16];
    wr   = 1'b1;
    res  = 32'd0;
    case (w[31:26])
      6'h00: begin
        dst = w[15:11];
        case (w[5:0])
          6'h00: res = b << w[10:6];
          6'h02: res = b >> w[10:6];
          6'h03: res = 32'(int'(b) >>> w[10:6]);
          6'h08: begin wr = 1'b0; npc = a; end
          6'h21: res = a + b;
          6'h23: res = a - b;
          6'h24: res = a & b;
          6'h25: res = a | b;
          6'h26: res = a ^ b;
          6'h27: res = ~(a | b);
          6'h2A: res = (int'(a) < int'(b)) ? 32'd1 : 32'd0;
          6'h2B: res = (a < b) ? 32'd1 : 32'd0;
          default: wr = 1'b0;
        endcase
      end
      6'h02: begin wr = 1'b0; npc = {npc[31:28], w[25:0], 2'b00}; end
      6'h03: begin dst = 5'd31; res = npc; npc = {npc[31:28], w[25:0], 2'b00}; end
      6'h04: begin wr = 1'b0; if (a == b) npc = npc + (simm << 2); end
      6'h05: begin wr = 1'b0; if (a != b) npc = npc + (simm << 2); end
      6'h09: res = a + simm;
      6'h0A: res = (int'(a) < int'(simm)) ? 32'd1 : 32'd0;
      6'h0B: res = (a < simm) ? 32'd1 : 32'd0;
      6'h0C: res = a & {16'd0, w[15:0]};
      6'h0D: res = a | {16'd0, w[15:0]};
      6'h0E: res = a ^ {16'd0, w[15:0]};
      6'h0F: res = {w[15:0], 16'd0};
      6'h23: res = m_mem.exists(k) ? m_mem[k] : 32'd0;
      6'h2B: begin wr = 1'b0; m_mem[k] = b; end
      default: wr = 1'b0;
    endcase
`ifdef SCCOMP_HALT_EN
    if (w == 32'h0000_000D) npc = m_pc;
`endif
    if (wr && dst != 5'd0) m_reg[dst] = res;
    m_pc = npc;
  endtask

  initial begin
    m_pc = PC_RESET;
    for (int i = 0; i < 32; i++) m_reg[i] = 32'd0;
    forever begin
      @(posedge clk_in or negedge reset);
      if (!reset) begin
        m_pc = PC_RESET;
        for (int i = 0; i < 32; i++) m_reg[i] = 32'd0;
      end else begin
        model_step();
      end
    end
  end

  // Compare process: DUT against model on every falling edge
  initial begin
    forever begin
      int bad;
      @(negedge clk_in);
      check("pc", pc, m_pc);
      check("inst", inst, m_prog[rom_index(m_pc)]);
      bad = 0;
      for (int i = 1; i < 32; i++) begin
        if (bad == 0 && gpr(i) !== m_reg[i]) bad = i;
      end
      check($sformatf("gpr[%0d]", bad), gpr(bad), m_reg[bad]);
    end
  end

  initial begin
    reset = 1'b0;
    load_prog(0);
    #40;
    check("rst_pc", pc, 32'h0040_0000);
    check("rst_inst", inst, 32'h340100FF);
    for (int i = 1; i < 32; i++) check($sformatf("rst_gpr[%0d]", i), gpr(i), 32'd0);
    #10;
    @(posedge clk_in); #3;
    reset = 1'b1;

    repeat (5) @(posedge clk_in);
    #3;
    check("jal_pc", pc, 32'h0040_0040);
    check("jal_ra", gpr(31), 32'h0040_0014);

    repeat (20) @(posedge clk_in);
    #3;
    check("beq_loop_pc", pc, 32'h0040_0034);
    check("addu_r3", gpr(3), 32'h800000FF);
    check("sra_r4", gpr(4), 32'hF8000000);
    check("slt_r5", gpr(5), 32'h00000001);
    check("sltu_r6", gpr(6), 32'h00000000);
    check("lw_r8", gpr(8), 32'h800000FF);
    check("sub_r9", gpr(9), 32'h00001234);
    check("subu_r10", gpr(10), 32'h80000000);
    check("zero_r0", gpr(0), 32'h00000000);
    check("model_r3", m_reg[3], 32'h800000FF);
    check("model_r8", m_reg[8], 32'h800000FF);
    check("model_pc", m_pc, 32'h0040_0034);

    reset = 1'b0;
    load_prog(1);
    repeat (3) @(posedge clk_in);
    #3;
    check("rst2_pc", pc, 32'h0040_0000);
    check("rst2_r3", gpr(3), 32'h00000000);
    reset = 1'b1;

    repeat (9) @(posedge clk_in);
    #3;
    check("nor_r3", gpr(3), 32'hFFFF0000);
    check("sll_r4", gpr(4), 32'h00F0F000);
    check("srl_r5", gpr(5), 32'h0FFFF000);
    check("sltiu_r6", gpr(6), 32'h00000001);
    check("slti_r7", gpr(7), 32'h00000001);
    check("andi_r8", gpr(8), 32'h00000000);
`ifdef SCCOMP_HALT_EN
    check("break_pc", pc, 32'h0040_0020);
`else
    check("break_pc", pc, 32'h0040_0024);
`endif

    repeat (10) @(posedge clk_in);
    #3;
`ifdef SCCOMP_HALT_EN
    check("halt_pc", pc, 32'h0040_0020);
    check("halt_r12", gpr(12), 32'h00000000);
    check("halt_r9", gpr(9), 32'h00000000);
`else
    check("run_pc", pc, 32'h0040_0034);
    check("addiu_r12", gpr(12), 32'hFFFFFFFE);
    check("or_r9", gpr(9), 32'h0000FFFF);
    check("xor_r10", gpr(10), 32'h00F000F0);
`endif
    check("model_r5", m_reg[5], 32'h0FFFF000);

    @(negedge clk_in);
    #1;
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
